typing_session_core: RTL and testbench

//  Parametrised game-session engine for the typing racer: fetches target words, edits the typed buffer, scores keystrokes, times the run, ends it.

---
 rtl/typing_session_core.sv | 207 ++++++++++++++++++++
 tb/tb_typing_session_core.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/typing_session_core.sv
// Typing racer session engine. It fetches target words, edits and scores the typed
// buffer, times the run, and derives accuracy and WPM with one shared serial divider.
module typing_session_core #(
  parameter int MAX_LEN = 25,
  parameter int LEN_W   = 5,
  parameter int CNT_W   = 11,
  parameter int MAX_CS  = 18000,
  parameter int DIV_W   = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 mode,
  input  logic [6:0]           limit,
  input  logic                 tick,
  input  logic                 key_valid,
  input  logic [4:0]           key_code,
  output logic                 word_req,
  input  logic                 word_ack,
  input  logic [MAX_LEN*5-1:0] word_in,
  input  logic [LEN_W-1:0]     word_len,
  output logic [MAX_LEN*5-1:0] typed,
  output logic [LEN_W-1:0]     cursor,
  output logic [LEN_W-1:0]     correct,
  output logic [CNT_W-1:0]     words_done,
  output logic [CNT_W-1:0]     words_ok,
  output logic [14:0]          elapsed,
  output logic                 busy,
  output logic                 done,
  output logic [9:0]           wpm,
  output logic [6:0]           acc,
  output logic                 stats_valid
);
  localparam int DVS_W = (CNT_W > 15) ? CNT_W : 15;
  localparam int DCNT_W = $clog2(DIV_W);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DIV_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_TYPE, S_DONE} state_t;
  typedef enum logic [1:0] {DV_IDLE, DV_RUN, DV_WRITE} div_state_t;

  state_t state, state_n;
  logic [MAX_LEN*5-1:0] target, target_n, typed_n;
  logic [LEN_W-1:0] tgt_len, tgt_len_n, cursor_n, correct_n;
  logic [CNT_W-1:0] words_done_n, words_ok_n, total, total_n, cc, cc_n;
  logic [14:0] elapsed_n;
  logic [6:0] lim_eff;
  logic [4:0] tgt_char;
  logic finish, clear, is_ok, chg;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? CNT_MAX : s[CNT_W-1:0];
  endfunction

  assign busy     = (state == S_FETCH) || (state == S_TYPE);
  assign done     = (state == S_DONE);
  assign word_req = (state == S_FETCH);
  assign lim_eff  = (limit == 7'd0) ? 7'd1 : limit;
  assign finish   = (elapsed >= 15'(MAX_CS)) ||
                    (!mode && (elapsed >= 15'(lim_eff) * 15'd100)) ||
                    (mode && (words_done >= CNT_W'(lim_eff)));

  always_comb begin
    state_n = state;  target_n = target;  tgt_len_n = tgt_len;
    typed_n = typed;  cursor_n = cursor;  correct_n = correct;
    words_done_n = words_done;  words_ok_n = words_ok;
    total_n = total;  cc_n = cc;  elapsed_n = elapsed;
    clear = 1'b0;  is_ok = 1'b0;  tgt_char = '0;
    if (cursor < LEN_W'(MAX_LEN)) tgt_char = target[5*int'(cursor) +: 5];
    if (abort) begin
      state_n = S_IDLE;
      clear = 1'b1;
    end else if (start && (state == S_IDLE || state == S_DONE)) begin
      state_n = S_FETCH;
      clear = 1'b1;
    end else begin
      if (busy && tick && (elapsed < 15'(MAX_CS))) elapsed_n = elapsed + 15'd1;
      if (busy && finish) begin
        state_n = S_DONE;
      end else if (state == S_FETCH && word_ack) begin
        target_n = word_in;
        tgt_len_n = word_len;
        state_n = S_TYPE;
      end else if (state == S_TYPE && key_valid) begin
        if (key_code >= 5'd1 && key_code <= 5'd26) begin
          if (cursor < LEN_W'(MAX_LEN)) begin
            typed_n[5*int'(cursor) +: 5] = key_code;
            cursor_n = cursor + 1'b1;
            total_n = sat_add(total, CNT_W'(1));
            if (correct == cursor && cursor < tgt_len && key_code == tgt_char)
              correct_n = correct + 1'b1;
          end
        end else if (key_code == 5'd27) begin
          if (cursor != '0) begin
            typed_n[5*(int'(cursor)-1) +: 5] = 5'd0;
            cursor_n = cursor - 1'b1;
            if (correct == cursor) correct_n = correct - 1'b1;
          end
        end else if (key_code == 5'd28) begin
          // A submitted word credits its matching prefix plus the space when exact.
          if (cursor != '0) begin
            is_ok = (correct == cursor) && (cursor == tgt_len);
            total_n = sat_add(total, CNT_W'(1));
            words_done_n = sat_add(words_done, CNT_W'(1));
            words_ok_n = sat_add(words_ok, CNT_W'(is_ok));
            cc_n = sat_add(cc, CNT_W'(correct) + CNT_W'(is_ok));
            typed_n = '0;
            cursor_n = '0;
            correct_n = '0;
            state_n = S_FETCH;
          end
        end
      end
    end
    if (clear) begin
      target_n = '0;  tgt_len_n = '0;  typed_n = '0;  cursor_n = '0;  correct_n = '0;
      words_done_n = '0;  words_ok_n = '0;  total_n = '0;  cc_n = '0;  elapsed_n = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;  target <= '0;  tgt_len <= '0;  typed <= '0;
      cursor <= '0;  correct <= '0;  words_done <= '0;  words_ok <= '0;
      total <= '0;  cc <= '0;  elapsed <= '0;
    end else begin
      state <= state_n;  target <= target_n;  tgt_len <= tgt_len_n;  typed <= typed_n;
      cursor <= cursor_n;  correct <= correct_n;  words_done <= words_done_n;
      words_ok <= words_ok_n;  total <= total_n;  cc <= cc_n;  elapsed <= elapsed_n;
    end
  end

  assign chg = !clear && ((total_n != total) || (cc_n != cc) || (correct_n != correct) ||
               (elapsed_n != elapsed) || (words_done_n != words_done) ||
               (words_ok_n != words_ok));

  div_state_t dv_state, dv_state_n;
  logic dv_sel, dv_sel_n, dirty, dirty_n, sv_n;
  logic [DIV_W-1:0] quo, quo_n, num;
  logic [DVS_W:0] rem, rem_n, rem_sh;
  logic [DVS_W-1:0] dvs, dvs_n;
  logic [DCNT_W-1:0] dv_cnt, dv_cnt_n;
  logic [9:0] wpm_n;
  logic [6:0] acc_n;

  assign num = DIV_W'(cc) + DIV_W'(correct);

  // Restoring divider: accuracy first, then WPM; a change mid-pair is picked up by a rerun.
  always_comb begin
    dv_state_n = dv_state;  dv_sel_n = dv_sel;  quo_n = quo;  rem_n = rem;
    dvs_n = dvs;  dv_cnt_n = dv_cnt;  wpm_n = wpm;  acc_n = acc;
    dirty_n = dirty;  sv_n = stats_valid;
    rem_sh = {rem[DVS_W-1:0], quo[DIV_W-1]};
    case (dv_state)
      DV_IDLE: if (dirty) begin
        quo_n = num * DIV_W'(100);  rem_n = '0;  dvs_n = DVS_W'(total);
        dv_cnt_n = '0;  dv_sel_n = 1'b0;  dirty_n = 1'b0;  dv_state_n = DV_RUN;
      end
      DV_RUN: begin
        if (rem_sh >= {1'b0, dvs}) begin
          rem_n = rem_sh - {1'b0, dvs};
          quo_n = {quo[DIV_W-2:0], 1'b1};
        end else begin
          rem_n = rem_sh;
          quo_n = {quo[DIV_W-2:0], 1'b0};
        end
        dv_cnt_n = dv_cnt + 1'b1;
        if (dv_cnt == DCNT_LAST) dv_state_n = DV_WRITE;
      end
      DV_WRITE: begin
        if (!dv_sel) begin
          acc_n = (dvs == '0) ? 7'd0 : quo[6:0];
          quo_n = num * DIV_W'(1200);  rem_n = '0;  dvs_n = DVS_W'(elapsed);
          dv_cnt_n = '0;  dv_sel_n = 1'b1;  dv_state_n = DV_RUN;
        end else begin
          wpm_n = (dvs == '0) ? 10'd0 : (quo > DIV_W'(999)) ? 10'd999 : quo[9:0];
          dv_state_n = DV_IDLE;
          if (!dirty) sv_n = 1'b1;
        end
      end
      default: dv_state_n = DV_IDLE;
    endcase
    if (chg) begin
      dirty_n = 1'b1;
      sv_n = 1'b0;
    end
    if (clear) begin
      dv_state_n = DV_IDLE;  dv_sel_n = 1'b0;  quo_n = '0;  rem_n = '0;  dvs_n = '0;
      dv_cnt_n = '0;  wpm_n = '0;  acc_n = '0;  dirty_n = 1'b0;  sv_n = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dv_state <= DV_IDLE;  dv_sel <= 1'b0;  quo <= '0;  rem <= '0;  dvs <= '0;
      dv_cnt <= '0;  wpm <= '0;  acc <= '0;  dirty <= 1'b0;  stats_valid <= 1'b1;
    end else begin
      dv_state <= dv_state_n;  dv_sel <= dv_sel_n;  quo <= quo_n;  rem <= rem_n;
      dvs <= dvs_n;  dv_cnt <= dv_cnt_n;  wpm <= wpm_n;  acc <= acc_n;
      dirty <= dirty_n;  stats_valid <= sv_n;
    end
  end
endmodule

// File: tb/tb_typing_session_core.sv
// Directed bench for typing_session_core: keystroke table for one word plus hand-written
// sequences for word/time limits, buffer overflow, stats, abort and reset.
module tb_typing_session_core;
  localparam int MAX_LEN = 25;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, abort = 1'b0, mode = 1'b0, tick = 1'b0;
  logic [6:0] limit = '0;
  logic key_valid = 1'b0;
  logic [4:0] key_code = '0;
  logic word_req, word_ack = 1'b0;
  logic [MAX_LEN*5-1:0] word_in = '0;
  logic [4:0] word_len = '0;
  logic [MAX_LEN*5-1:0] typed;
  logic [4:0] cursor, correct;
  logic [10:0] words_done, words_ok;
  logic [14:0] elapsed;
  logic busy, done, stats_valid;
  logic [9:0] wpm;
  logic [6:0] acc;

  int unsigned n_vectors = 0;
  int unsigned n_miscompares = 0;

  typedef struct {
    logic       key_valid;
    logic [4:0] key_code;
    logic       tick;
    logic [4:0] exp_cursor;
    logic [4:0] exp_correct;
    logic [10:0] exp_words_done;
    logic [10:0] exp_words_ok;
  } vec_t;

  vec_t vecs[10];

  typing_session_core dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode), .limit(limit),
    .tick(tick), .key_valid(key_valid), .key_code(key_code), .word_req(word_req),
    .word_ack(word_ack), .word_in(word_in), .word_len(word_len), .typed(typed),
    .cursor(cursor), .correct(correct), .words_done(words_done), .words_ok(words_ok),
    .elapsed(elapsed), .busy(busy), .done(done), .wpm(wpm), .acc(acc),
    .stats_valid(stats_valid)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic kv, input logic [4:0] kc, input logic tk);
    @(negedge clk);
    key_valid = kv;  key_code = kc;  tick = tk;
    @(posedge clk);
    #1;
    key_valid = 1'b0;  tick = 1'b0;
  endtask

  task automatic pulse_ctrl(input logic s, input logic a);
    @(negedge clk);
    start = s;  abort = a;
    @(posedge clk);
    #1;
    start = 1'b0;  abort = 1'b0;
  endtask

  task automatic fetch_word(input logic [4:0] c0, input logic [4:0] c1,
                            input logic [4:0] c2);
    @(negedge clk);
    word_in = '0;
    word_in[4:0] = c0;  word_in[9:5] = c1;  word_in[14:10] = c2;
    word_len = 5'd3;  word_ack = 1'b1;
    @(posedge clk);
    #1;
    word_ack = 1'b0;
  endtask

  task automatic wait_stats();
    int cycles;
    cycles = 0;
    while (stats_valid !== 1'b1 && cycles < 400) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check_output("stats_settle", 32'(stats_valid), 32'd1);
  endtask

  initial begin
    // target "dog": d=4 o=15 g=7, x=24
    vecs[0] = '{1'b1, 5'd27, 1'b0, 5'd0, 5'd0, 11'd0, 11'd0};
    vecs[1] = '{1'b1, 5'd28, 1'b0, 5'd0, 5'd0, 11'd0, 11'd0};
    vecs[2] = '{1'b1, 5'd0,  1'b0, 5'd0, 5'd0, 11'd0, 11'd0};
    vecs[3] = '{1'b1, 5'd29, 1'b0, 5'd0, 5'd0, 11'd0, 11'd0};
    vecs[4] = '{1'b1, 5'd4,  1'b0, 5'd1, 5'd1, 11'd0, 11'd0};
    vecs[5] = '{1'b1, 5'd24, 1'b0, 5'd2, 5'd1, 11'd0, 11'd0};
    vecs[6] = '{1'b1, 5'd27, 1'b0, 5'd1, 5'd1, 11'd0, 11'd0};
    vecs[7] = '{1'b1, 5'd15, 1'b0, 5'd2, 5'd2, 11'd0, 11'd0};
    vecs[8] = '{1'b1, 5'd7,  1'b0, 5'd3, 5'd3, 11'd0, 11'd0};
    vecs[9] = '{1'b1, 5'd28, 1'b0, 5'd0, 5'd0, 11'd1, 11'd1};

    #12;
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_word_req", 32'(word_req), 32'd0);
    check_output("rst_stats_valid", 32'(stats_valid), 32'd1);
    check_output("rst_wpm", 32'(wpm), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    mode = 1'b1;  limit = 7'd10;
    pulse_ctrl(1'b1, 1'b0);
    check_output("start_word_req", 32'(word_req), 32'd1);
    fetch_word(5'd4, 5'd15, 5'd7);
    check_output("ack_word_req", 32'(word_req), 32'd0);
    check_output("ack_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(vecs[i].key_valid, vecs[i].key_code, vecs[i].tick);
      check_output($sformatf("vec%0d_cursor", i), 32'(cursor), 32'(vecs[i].exp_cursor));
      check_output($sformatf("vec%0d_correct", i), 32'(correct), 32'(vecs[i].exp_correct));
      check_output($sformatf("vec%0d_words_done", i), 32'(words_done), 32'(vecs[i].exp_words_done));
      check_output($sformatf("vec%0d_words_ok", i), 32'(words_ok), 32'(vecs[i].exp_words_ok));
    end
    check_output("dog_refetch", 32'(word_req), 32'd1);
    wait_stats();
    check_output("dog_acc", 32'(acc), 32'd80);
    check_output("dog_wpm_zero_elapsed", 32'(wpm), 32'd0);

    // "cat" with a correcting backspace, then overfill the buffer
    fetch_word(5'd3, 5'd1, 5'd20);
    apply_stimulus(1'b1, 5'd3, 1'b0);
    apply_stimulus(1'b1, 5'd1, 1'b0);
    apply_stimulus(1'b1, 5'd27, 1'b0);
    check_output("bksp_correct", 32'(correct), 32'd1);
    apply_stimulus(1'b1, 5'd1, 1'b0);
    apply_stimulus(1'b1, 5'd20, 1'b0);
    check_output("cat_correct", 32'(correct), 32'd3);
    for (int i = 0; i < 23; i++) apply_stimulus(1'b1, 5'd26, 1'b0);
    check_output("full_cursor", 32'(cursor), 32'd25);
    check_output("full_correct", 32'(correct), 32'd3);
    check_output("slot0", 32'(typed[4:0]), 32'd3);
    check_output("slot24", 32'(typed[124:120]), 32'd26);
    wait_stats();
    check_output("full_acc", 32'(acc), 32'd22);
    apply_stimulus(1'b0, 5'd0, 1'b1);
    check_output("tick_elapsed", 32'(elapsed), 32'd1);
    check_output("tick_invalidates", 32'(stats_valid), 32'd0);
    wait_stats();
    check_output("wpm_sat", 32'(wpm), 32'd999);
    for (int i = 0; i < 59; i++) apply_stimulus(1'b0, 5'd0, 1'b1);
    wait_stats();
    check_output("wpm_60cs", 32'(wpm), 32'd140);
    check_output("acc_60cs", 32'(acc), 32'd22);

    // abort while the divider is busy
    apply_stimulus(1'b0, 5'd0, 1'b1);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 5'd0, 1'b0);
    check_output("mid_divide_invalid", 32'(stats_valid), 32'd0);
    pulse_ctrl(1'b0, 1'b1);
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_elapsed", 32'(elapsed), 32'd0);
    check_output("abort_wpm", 32'(wpm), 32'd0);
    check_output("abort_acc", 32'(acc), 32'd0);
    check_output("abort_stats_valid", 32'(stats_valid), 32'd1);
    check_output("abort_typed_empty", 32'(typed != '0), 32'd0);
    fetch_word(5'd3, 5'd1, 5'd20);
    check_output("idle_ack_ignored", 32'(busy), 32'd0);

    // word-limit run: two exact "cat" words
    mode = 1'b1;  limit = 7'd2;
    pulse_ctrl(1'b1, 1'b0);
    apply_stimulus(1'b0, 5'd0, 1'b0);
    check_output("req_held", 32'(word_req), 32'd1);
    for (int w = 0; w < 2; w++) begin
      fetch_word(5'd3, 5'd1, 5'd20);
      apply_stimulus(1'b1, 5'd3, 1'b0);
      apply_stimulus(1'b1, 5'd1, 1'b0);
      apply_stimulus(1'b1, 5'd20, 1'b0);
      apply_stimulus(1'b1, 5'd28, 1'b0);
    end
    check_output("words_ok2", 32'(words_ok), 32'd2);
    apply_stimulus(1'b0, 5'd0, 1'b0);
    check_output("words_done_flag", 32'(done), 32'd1);
    check_output("done_word_req", 32'(word_req), 32'd0);
    apply_stimulus(1'b1, 5'd1, 1'b0);
    check_output("done_key_ignored", 32'(cursor), 32'd0);
    wait_stats();
    check_output("words_acc", 32'(acc), 32'd100);

    // time-limit run, 1 second
    mode = 1'b0;  limit = 7'd1;
    pulse_ctrl(1'b1, 1'b0);
    check_output("restart_words_done", 32'(words_done), 32'd0);
    check_output("restart_acc", 32'(acc), 32'd0);
    fetch_word(5'd3, 5'd1, 5'd20);
    for (int i = 0; i < 49; i++) apply_stimulus(1'b0, 5'd0, 1'b1);
    apply_stimulus(1'b1, 5'd3, 1'b1);
    check_output("tick_key_elapsed", 32'(elapsed), 32'd50);
    check_output("tick_key_cursor", 32'(cursor), 32'd1);
    for (int i = 0; i < 49; i++) apply_stimulus(1'b0, 5'd0, 1'b1);
    check_output("time_99_not_done", 32'(done), 32'd0);
    apply_stimulus(1'b0, 5'd0, 1'b1);
    check_output("time_elapsed_100", 32'(elapsed), 32'd100);
    apply_stimulus(1'b1, 5'd1, 1'b0);
    check_output("time_done", 32'(done), 32'd1);
    check_output("finish_key_dropped", 32'(cursor), 32'd1);
    wait_stats();
    check_output("time_acc", 32'(acc), 32'd100);
    check_output("time_wpm", 32'(wpm), 32'd12);

    // limit 0 behaves as one word
    mode = 1'b1;  limit = 7'd0;
    pulse_ctrl(1'b1, 1'b0);
    fetch_word(5'd3, 5'd1, 5'd20);
    apply_stimulus(1'b1, 5'd3, 1'b0);
    apply_stimulus(1'b1, 5'd24, 1'b0);
    apply_stimulus(1'b1, 5'd28, 1'b0);
    check_output("lim0_words_ok", 32'(words_ok), 32'd0);
    apply_stimulus(1'b0, 5'd0, 1'b0);
    check_output("lim0_done", 32'(done), 32'd1);
    wait_stats();
    check_output("lim0_acc", 32'(acc), 32'd33);

    // asynchronous reset mid-word
    limit = 7'd5;
    pulse_ctrl(1'b1, 1'b0);
    fetch_word(5'd3, 5'd1, 5'd20);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 5'd26, 1'b0);
    check_output("pre_rst_cursor", 32'(cursor), 32'd3);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_output("async_rst_cursor", 32'(cursor), 32'd0);
    check_output("async_rst_busy", 32'(busy), 32'd0);
    check_output("async_rst_typed", 32'(typed != '0), 32'd0);
    check_output("async_rst_sv", 32'(stats_valid), 32'd1);
    @(negedge clk);
    rst = 1'b1;

    // hard centisecond cap
    mode = 1'b1;  limit = 7'd100;
    pulse_ctrl(1'b1, 1'b0);
    fetch_word(5'd3, 5'd1, 5'd20);
    for (int i = 0; i < 18010; i++) apply_stimulus(1'b0, 5'd0, 1'b1);
    check_output("cap_elapsed", 32'(elapsed), 32'd18000);
    check_output("cap_done", 32'(done), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end
endmodule
